// File: rtl/instr_issuer.sv
// instr_issuer: fetches words from a synchronous program ROM, issues mv/mvi/add/sub over run/done.
// Optional watchdog on done is enabled by defining INSTR_ISSUER_WATCHDOG_EN.
module instr_issuer #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [8:0]        ir,
    output logic [15:0]       din,
    output logic              run,
    input  logic              done,
    output logic              busy,
    output logic              halted,
    output logic [7:0]        instr_count,
    output logic              wd_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_FETCH_IMM,
        S_IMM,
        S_ISSUE,
        S_WAIT_DONE,
        S_HALTED
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [8:0]        ir_reg, ir_next;
    logic [15:0]       din_reg, din_next;
    logic [7:0]        count_reg, count_next;
    logic [2:0]        opcode;

    assign opcode = rom_data[8:6];

    generate
        if (ADDR_W < 1 || TIMEOUT < 1) begin : g_param_check
            $error("instr_issuer: ADDR_W and TIMEOUT must be at least 1");
        end
    endgenerate

`ifdef INSTR_ISSUER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic            wd_err_reg, wd_err_next;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            pc_reg     <= '0;
            ir_reg     <= '0;
            din_reg    <= '0;
            count_reg  <= '0;
`ifdef INSTR_ISSUER_WATCHDOG_EN
            wd_cnt_reg <= '0;
            wd_err_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            din_reg    <= din_next;
            count_reg  <= count_next;
`ifdef INSTR_ISSUER_WATCHDOG_EN
            wd_cnt_reg <= wd_cnt_next;
            wd_err_reg <= wd_err_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        ir_next     = ir_reg;
        din_next    = din_reg;
        count_next  = count_reg;
`ifdef INSTR_ISSUER_WATCHDOG_EN
        wd_cnt_next = wd_cnt_reg;
        wd_err_next = wd_err_reg;
`endif
        unique case (state_reg)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_next  = S_FETCH;
                    pc_next     = '0;
                    count_next  = '0;
`ifdef INSTR_ISSUER_WATCHDOG_EN
                    wd_err_next = 1'b0;
`endif
                end
            end
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                // pc advances past every decoded word, including HALT and NOP
                pc_next = pc_reg + ADDR_W'(1);
                unique case (opcode)
                    3'b111:                 state_next = S_HALTED;
                    3'b100, 3'b101, 3'b110: state_next = S_FETCH;
                    3'b001: begin
                        ir_next    = rom_data[8:0];
                        state_next = S_FETCH_IMM;
                    end
                    default: begin
                        ir_next    = rom_data[8:0];
                        din_next   = '0;
                        state_next = S_ISSUE;
                    end
                endcase
            end
            S_FETCH_IMM: state_next = S_IMM;
            S_IMM: begin
                din_next   = rom_data;
                pc_next    = pc_reg + ADDR_W'(1);
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (count_reg != 8'hFF) count_next = count_reg + 8'd1;
`ifdef INSTR_ISSUER_WATCHDOG_EN
                wd_cnt_next = '0;
`endif
                state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done) begin
                    state_next = S_FETCH;
                end
`ifdef INSTR_ISSUER_WATCHDOG_EN
                else if (wd_cnt_reg == WD_W'(TIMEOUT - 1)) begin
                    wd_err_next = 1'b1;
                    state_next  = S_HALTED;
                end else begin
                    wd_cnt_next = wd_cnt_reg + WD_W'(1);
                end
`endif
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign rom_addr    = pc_reg;
    assign ir          = ir_reg;
    assign din         = din_reg;
    assign instr_count = count_reg;
    assign run         = (state_reg == S_ISSUE);
    assign busy        = (state_reg != S_IDLE) && (state_reg != S_HALTED);
    assign halted      = (state_reg == S_HALTED);
`ifdef INSTR_ISSUER_WATCHDOG_EN
    assign wd_error    = wd_err_reg;
`else
    assign wd_error    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: directed scenarios plus random programs
// checked against a program-walking reference model.
module tb_instr_issuer;

    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          done  = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic [8:0]    ir;
    logic [15:0]   din;
    logic          run, busy, halted, wd_error;
    logic [7:0]    instr_count;
    logic [15:0]   rom [DEPTH];

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= rom[rom_addr];

    instr_issuer #(.ADDR_W(AW), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .start(start), .rom_addr(rom_addr),
        .rom_data(rom_data), .ir(ir), .din(din), .run(run), .done(done),
        .busy(busy), .halted(halted), .instr_count(instr_count), .wd_error(wd_error)
    );

    // Walk the program from pc: skip NOPs, stop at HALT or the next issued instruction.
    // lat counts falling edges after the start/done sampling edge until run or halted shows.
    function automatic void model_next(input int pc_in, output int pc_out, output bit halt,
                                       output logic [8:0] e_ir, output logic [15:0] e_din,
                                       output int lat);
        int pc;
        logic [15:0] w;
        pc = pc_in; lat = 3; halt = 0; e_ir = '0; e_din = '0;
        for (int step = 0; step < DEPTH; step++) begin
            w  = rom[pc];
            pc = (pc + 1) % DEPTH;
            if (w[8:6] >= 3'd4 && w[8:6] <= 3'd6) begin
                lat += 2;
                continue;
            end
            if (w[8:6] == 3'd7) begin
                halt = 1;
                break;
            end
            e_ir = w[8:0];
            if (w[8:6] == 3'd1) begin
                e_din = rom[pc];
                pc    = (pc + 1) % DEPTH;
                lat  += 2;
            end
            break;
        end
        pc_out = pc;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < DEPTH; i++) rom[i] = w;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic give_done(input int delay);
        repeat (delay) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; done = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Observation only: falling edges until run or halted is seen, bounded by budget.
    task automatic watch(input int budget, output int lat, output bit saw_run, output bit saw_halt);
        lat = 0; saw_run = 0; saw_halt = 0;
        while (lat < budget && !saw_run && !saw_halt) begin
            @(negedge clock);
            lat++;
            saw_run  = run;
            saw_halt = halted;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({run, busy, halted, wd_error} !== 4'b0000)
            $display("FAIL reset_flags: got run/busy/halted/wd=%b want 0000", {run, busy, halted, wd_error});
        else passed++;
        checks++;
        if (ir !== 9'h000 || din !== 16'h0000 || rom_addr !== '0 || instr_count !== 8'd0)
            $display("FAIL reset_regs: got ir=%h din=%h addr=%0d cnt=%0d want 0", ir, din, rom_addr, instr_count);
        else passed++;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_mvi_add();
        int lat; bit sr, sh;
        fill_rom(16'h01C0);
        rom[0] = 16'h0040; rom[1] = 16'h0005; rom[2] = 16'h0080; rom[3] = 16'h01C0;
        pulse_start();
        watch(12, lat, sr, sh);
        checks++;
        if (!sr || lat !== 5 || ir !== 9'h040 || din !== 16'h0005)
            $display("FAIL mvi_issue: got run=%b lat=%0d ir=%h din=%h want 1 5 040 0005", sr, lat, ir, din);
        else passed++;
        tick();
        checks++;
        if (run !== 1'b0) $display("FAIL run_width: got run=%b in cycle after issue want 0", run);
        else passed++;
        give_done(1);
        watch(12, lat, sr, sh);
        checks++;
        if (!sr || lat !== 3 || ir !== 9'h080 || din !== 16'h0000)
            $display("FAIL add_issue: got run=%b lat=%0d ir=%h din=%h want 1 3 080 0000", sr, lat, ir, din);
        else passed++;
        tick();
        give_done(1);
        watch(12, lat, sr, sh);
        checks++;
        if (!sh || lat !== 3 || instr_count !== 8'd2 || rom_addr !== AW'(4) || busy !== 1'b0)
            $display("FAIL mvi_add_halt: got halted=%b lat=%0d cnt=%0d addr=%0d busy=%b want 1 3 2 4 0",
                     sh, lat, instr_count, rom_addr, busy);
        else passed++;
        tick();
    endtask

    task automatic test_stall();
        int lat, extra_runs, bad; bit sr, sh;
        fill_rom(16'h01C0);
        rom[0] = 16'h0008;
        pulse_start();
        watch(12, lat, sr, sh);
        checks++;
        if (!sr || lat !== 3 || ir !== 9'h008)
            $display("FAIL stall_issue: got run=%b lat=%0d ir=%h want 1 3 008", sr, lat, ir);
        else passed++;
        done = 1'b1;            // sampled while in ISSUE: must be ignored
        tick();
        done  = 1'b0;
        start = 1'b1;           // start while busy: must be ignored
        tick();
        start = 1'b0;
        extra_runs = 0; bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (run === 1'b1) extra_runs++;
            if (ir !== 9'h008 || din !== 16'h0000 || busy !== 1'b1 || halted !== 1'b0 || wd_error !== 1'b0) bad++;
        end
        checks++;
        if (extra_runs !== 0) $display("FAIL stall_runs: got %0d extra run pulses want 0", extra_runs);
        else passed++;
        checks++;
        if (bad !== 0) $display("FAIL stall_hold: got %0d cycles with ir/din/busy disturbed want 0", bad);
        else passed++;
        tick();
        give_done(0);
        watch(12, lat, sr, sh);
        checks++;
        if (!sh || lat !== 3 || instr_count !== 8'd1)
            $display("FAIL stall_halt: got halted=%b lat=%0d cnt=%0d want 1 3 1", sh, lat, instr_count);
        else passed++;
        tick();
    endtask

    task automatic test_nop();
        int lat; bit sr, sh;
        fill_rom(16'h01C0);
        rom[0] = 16'h0100;
        pulse_start();
        watch(12, lat, sr, sh);
        checks++;
        if (sr || !sh || lat !== 5 || instr_count !== 8'd0 || rom_addr !== AW'(2))
            $display("FAIL nop_halt: got run=%b halted=%b lat=%0d cnt=%0d addr=%0d want 0 1 5 0 2",
                     sr, sh, lat, instr_count, rom_addr);
        else passed++;
        tick();
    endtask

    task automatic test_wrap();
        int lat; bit sr, sh;
        int          e_lat [4] = '{3, 3, 3, 61};
        logic [8:0]  e_ir  [4] = '{9'h080, 9'h0C0, 9'h080, 9'h040};
        logic [15:0] e_din [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0080};
        fill_rom(16'h0100);
        rom[0] = 16'h0080; rom[1] = 16'h00C0; rom[2] = 16'h0080; rom[31] = 16'h0040;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            watch(80, lat, sr, sh);
            checks++;
            if (!sr || lat !== e_lat[i] || ir !== e_ir[i] || din !== e_din[i])
                $display("FAIL wrap_issue%0d: got run=%b lat=%0d ir=%h din=%h want 1 %0d %h %h",
                         i, sr, lat, ir, din, e_lat[i], e_ir[i], e_din[i]);
            else passed++;
            tick();
            if (i == 3) rom[1] = 16'h01C0;
            give_done(i);
        end
        watch(12, lat, sr, sh);
        checks++;
        if (!sh || lat !== 3 || instr_count !== 8'd4 || rom_addr !== AW'(2))
            $display("FAIL wrap_halt: got halted=%b lat=%0d cnt=%0d addr=%0d want 1 3 4 2",
                     sh, lat, instr_count, rom_addr);
        else passed++;
        tick();
    endtask

    task automatic test_async_reset();
        int lat; bit sr, sh;
        fill_rom(16'h01C0);
        rom[0] = 16'h00C0;
        pulse_start();
        watch(12, lat, sr, sh);
        tick();
        #2;
        reset = 1'b1;           // mid-cycle in WAIT_DONE
        #1;
        checks++;
        if (run !== 1'b0 || busy !== 1'b0 || ir !== 9'h000 || instr_count !== 8'd0)
            $display("FAIL reset_wait: got run=%b busy=%b ir=%h cnt=%0d want 0 0 000 0", run, busy, ir, instr_count);
        else passed++;
        tick();
        reset = 1'b0;
        pulse_start();
        watch(12, lat, sr, sh);
        reset = 1'b1;           // mid-cycle while run is high
        #1;
        checks++;
        if (!sr || run !== 1'b0 || busy !== 1'b0 || ir !== 9'h000)
            $display("FAIL reset_issue: got seen=%b run=%b busy=%b ir=%h want 1 0 0 000", sr, run, busy, ir);
        else passed++;
        tick();
        reset = 1'b0;
        pulse_start();
        watch(12, lat, sr, sh);
        checks++;
        if (!sr || lat !== 3 || ir !== 9'h0C0)
            $display("FAIL reset_restart: got run=%b lat=%0d ir=%h want 1 3 0c0", sr, lat, ir);
        else passed++;
        tick();
        do_reset();
    endtask

    task automatic test_saturate();
        int lat, bad; bit sr, sh;
        fill_rom(16'h0008);
        pulse_start();
        bad = 0;
        for (int i = 0; i < 260; i++) begin
            watch(8, lat, sr, sh);
            if (!sr) begin
                bad++;
                break;
            end
            tick();
            if (instr_count !== 8'((i + 1 > 255) ? 255 : i + 1)) bad++;
            give_done(0);
        end
        checks++;
        if (bad !== 0 || instr_count !== 8'd255)
            $display("FAIL saturate: got %0d bad steps, final cnt=%0d want 0 255", bad, instr_count);
        else passed++;
        do_reset();
    endtask

    task automatic test_watchdog();
        int lat; bit sr, sh;
        fill_rom(16'h01C0);
        rom[0] = 16'h0008;
        pulse_start();
        watch(12, lat, sr, sh);
        tick();
`ifdef INSTR_ISSUER_WATCHDOG_EN
        watch(30, lat, sr, sh);
        checks++;
        if (!sh || lat !== 16 || wd_error !== 1'b1)
            $display("FAIL watchdog: got halted=%b lat=%0d wd=%b want 1 16 1", sh, lat, wd_error);
        else passed++;
        tick();
        pulse_start();
        checks++;
        if (wd_error !== 1'b0) $display("FAIL watchdog_clear: got wd=%b want 0", wd_error);
        else passed++;
`else
        repeat (40) @(negedge clock);
        checks++;
        if (busy !== 1'b1 || halted !== 1'b0 || wd_error !== 1'b0 || run !== 1'b0)
            $display("FAIL wait_forever: got busy=%b halted=%b wd=%b run=%b want 1 0 0 0",
                     busy, halted, wd_error, run);
        else passed++;
        tick();
`endif
        do_reset();
    endtask

    task automatic test_random_programs();
        int pc, npc, e_lat, lat, n, r;
        bit halt, sr, sh;
        logic [8:0]  e_ir;
        logic [15:0] e_din, w;
        for (int p = 0; p < 25; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                r = int'($urandom_range(0, 15));
                w = 16'($urandom);
                if (r < 12)      w[8:6] = 3'(r % 4);
                else if (r < 14) w[8:6] = 3'(4 + $urandom_range(0, 2));
                else             w[8:6] = 3'd7;
                if (i == 0 && w[8:6] >= 3'd4 && w[8:6] <= 3'd6) w[8:6] = 3'd2;
                rom[i] = w;
            end
            pulse_start();
            pc = 0; n = 0;
            for (int s = 0; s < 10; s++) begin
                model_next(pc, npc, halt, e_ir, e_din, e_lat);
                watch(e_lat + 4, lat, sr, sh);
                checks++;
                if (halt) begin
                    if (!sh || lat !== e_lat || instr_count !== 8'(n) || rom_addr !== AW'(npc))
                        $display("FAIL rand_halt p%0d: got halted=%b lat=%0d cnt=%0d addr=%0d want 1 %0d %0d %0d",
                                 p, sh, lat, instr_count, rom_addr, e_lat, n, npc);
                    else passed++;
                    break;
                end
                if (!sr || lat !== e_lat || ir !== e_ir || din !== e_din)
                    $display("FAIL rand_issue p%0d s%0d: got run=%b lat=%0d ir=%h din=%h want 1 %0d %h %h",
                             p, s, sr, lat, ir, din, e_lat, e_ir, e_din);
                else passed++;
                if (!sr) break;
                n++;
                pc = npc;
                tick();
                give_done(int'($urandom_range(0, 3)));
            end
            tick();
            do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_mvi_add();
        test_stall();
        test_nop();
        test_wrap();
        test_async_reset();
        test_saturate();
        test_watchdog();
        test_random_programs();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
